// File: rtl/mc16_control_unit.sv
// mc16_control_unit: multi-cycle control FSM for the 16-bit RISC computer.
// It holds the IR, the stored NZVC flags and the sequencing state. Every
// datapath select, enable and memory strobe is decoded from the registered
// state and IR. The only exceptions are the FETCH PC load and the MEM_RD
// MDR load, which are also gated by mem_ready.
//
// Build option MC16_MEM_WAIT_EN:
//   defined   - FETCH, MEM_RD and MEM_WR stall until mem_ready is high.
//   undefined - mem_ready is ignored, and every memory access takes one cycle.
module mc16_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [3:0]  NZVC,
  output logic [15:0] Instr,
  output logic [2:0]  Rd_ddd_to_RF,
  output logic [2:0]  Rm_mmm_to_RF,
  output logic [2:0]  Rn_nnn_to_RF,
  output logic        ALU_A_Sel,
  output logic [1:0]  ALU_B_Sel,
  output logic [1:0]  Imm_Sel,
  output logic        ALU_Control,
  output logic        RA_Data_CE,
  output logic        RB_Data_CE,
  output logic        ALUOut_CE,
  output logic        RF_Write_en,
  output logic        Mem_to_RF_Sel,
  output logic        PC_Write_en,
  output logic        PC_Src,
  output logic        IorD,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic        MDR_CE,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_HALTED
  } state_t;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_ADDI  = 5'b00010;
  localparam logic [4:0] OP_SUBI  = 5'b00011;
  localparam logic [4:0] OP_ADDI8 = 5'b00100;
  localparam logic [4:0] OP_LDR   = 5'b00101;
  localparam logic [4:0] OP_STR   = 5'b00110;
  localparam logic [4:0] OP_B     = 5'b00111;
  localparam logic [4:0] OP_BEQ   = 5'b01000;
  localparam logic [4:0] OP_CMP   = 5'b01001;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  state_t      state;
  logic [15:0] ir;
  logic [3:0]  flags;
  logic [4:0]  opcode;
  logic        op_legal;
  logic        mem_rdy;

  assign opcode   = ir[15:11];
  // The opcodes 00000..01001 are contiguous, and HALT is the only other legal opcode.
  assign op_legal = (opcode <= OP_CMP) || (opcode == OP_HALT);

`ifdef MC16_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_rdy          = 1'b1;
`endif

  // BEQ is the only consumer of the stored flags, so only Z leaves this block.
  logic unused_flags;
  assign unused_flags = ^{flags[3], flags[1:0]};

  assign Instr        = ir;
  assign Rd_ddd_to_RF = ir[10:8];
  assign Rm_mmm_to_RF = (opcode == OP_ADDI8) ? ir[10:8] : ir[7:5];
  assign Rn_nnn_to_RF = (opcode == OP_STR)   ? ir[10:8] : ir[4:2];

  // Sequencing state, instruction register and stored flags.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before the edge, whatever the statement order.
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
      flags <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_rdy) begin
            ir    <= mem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_B, OP_BEQ:   state <= S_BRANCH;
            OP_HALT:        state <= S_HALTED;
            OP_LDR, OP_STR: state <= S_MEM_ADDR;
            default:        state <= op_legal ? S_EXEC : S_FETCH;
          endcase
        end
        S_EXEC: begin
          flags <= NZVC;
          state <= (opcode == OP_CMP) ? S_FETCH : S_WB_ALU;
        end
        S_WB_ALU:   state <= S_FETCH;
        S_MEM_ADDR: state <= (opcode == OP_LDR) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_rdy) state <= S_WB_MEM;
        S_WB_MEM:   state <= S_FETCH;
        S_MEM_WR:   if (mem_rdy) state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_HALTED:   state <= S_HALTED;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of datapath controls. While rst is high, enables and strobes
  // are forced low so that an aborted instruction cannot write anything.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would infer a latch.
    ALU_A_Sel     = 1'b1;
    ALU_B_Sel     = 2'b00;
    Imm_Sel       = 2'b00;
    ALU_Control   = 1'b0;
    RA_Data_CE    = 1'b0;
    RB_Data_CE    = 1'b0;
    ALUOut_CE     = 1'b0;
    RF_Write_en   = 1'b0;
    Mem_to_RF_Sel = 1'b0;
    PC_Write_en   = 1'b0;
    PC_Src        = 1'b0;
    IorD          = 1'b0;
    Mem_Read      = 1'b0;
    Mem_Write     = 1'b0;
    MDR_CE        = 1'b0;
    halted        = 1'b0;
    illegal       = 1'b0;

    case (state)
      S_FETCH: begin
        Mem_Read    = 1'b1;
        ALU_A_Sel   = 1'b0;
        ALU_B_Sel   = 2'b10;
        PC_Write_en = mem_rdy;
      end
      S_DECODE: begin
        RA_Data_CE = 1'b1;
        RB_Data_CE = 1'b1;
        ALUOut_CE  = 1'b1;
        ALU_A_Sel  = 1'b0;
        ALU_B_Sel  = 2'b01;
        Imm_Sel    = 2'b01;
        illegal    = !op_legal;
      end
      S_EXEC: begin
        ALUOut_CE   = 1'b1;
        ALU_B_Sel   = (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_CMP)
                      ? 2'b00 : 2'b01;
        Imm_Sel     = (opcode == OP_ADDI8) ? 2'b01 : 2'b00;
        ALU_Control = (opcode == OP_SUB || opcode == OP_SUBI || opcode == OP_CMP);
      end
      S_WB_ALU: RF_Write_en = 1'b1;
      S_MEM_ADDR: begin
        ALUOut_CE = 1'b1;
        ALU_B_Sel = 2'b01;
      end
      S_MEM_RD: begin
        Mem_Read = 1'b1;
        IorD     = 1'b1;
        MDR_CE   = mem_rdy;
      end
      S_WB_MEM: begin
        RF_Write_en   = 1'b1;
        Mem_to_RF_Sel = 1'b1;
      end
      S_MEM_WR: begin
        Mem_Write = 1'b1;
        IorD      = 1'b1;
      end
      S_BRANCH: begin
        PC_Src      = 1'b1;
        PC_Write_en = (opcode == OP_B) || (opcode == OP_BEQ && flags[2]);
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase

    if (rst) begin
      RA_Data_CE    = 1'b0;
      RB_Data_CE    = 1'b0;
      ALUOut_CE     = 1'b0;
      RF_Write_en   = 1'b0;
      Mem_to_RF_Sel = 1'b0;
      PC_Write_en   = 1'b0;
      PC_Src        = 1'b0;
      IorD          = 1'b0;
      Mem_Read      = 1'b0;
      Mem_Write     = 1'b0;
      MDR_CE        = 1'b0;
      halted        = 1'b0;
      illegal       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc16_control_unit.sv
// Testbench for mc16_control_unit: directed per-cycle vector table,
// hand-written wait-state / reset / halt sequences, and randomized
// instruction streams against an instruction-level reference model.
module tb_mc16_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [3:0]  NZVC = '0;
  logic [15:0] Instr;
  logic [2:0]  Rd_ddd_to_RF, Rm_mmm_to_RF, Rn_nnn_to_RF;
  logic        ALU_A_Sel;
  logic [1:0]  ALU_B_Sel, Imm_Sel;
  logic        ALU_Control, RA_Data_CE, RB_Data_CE, ALUOut_CE, RF_Write_en;
  logic        Mem_to_RF_Sel, PC_Write_en, PC_Src, IorD, Mem_Read, Mem_Write;
  logic        MDR_CE, halted, illegal;

  mc16_control_unit dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .NZVC(NZVC),
    .Instr(Instr), .Rd_ddd_to_RF(Rd_ddd_to_RF), .Rm_mmm_to_RF(Rm_mmm_to_RF),
    .Rn_nnn_to_RF(Rn_nnn_to_RF), .ALU_A_Sel(ALU_A_Sel), .ALU_B_Sel(ALU_B_Sel),
    .Imm_Sel(Imm_Sel), .ALU_Control(ALU_Control), .RA_Data_CE(RA_Data_CE),
    .RB_Data_CE(RB_Data_CE), .ALUOut_CE(ALUOut_CE), .RF_Write_en(RF_Write_en),
    .Mem_to_RF_Sel(Mem_to_RF_Sel), .PC_Write_en(PC_Write_en), .PC_Src(PC_Src),
    .IorD(IorD), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .MDR_CE(MDR_CE),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

`ifdef MC16_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  // Strobe vector bit masks.
  localparam logic [12:0] K_RA  = 13'h1000, K_RB  = 13'h0800, K_AO  = 13'h0400;
  localparam logic [12:0] K_RFW = 13'h0200, K_M2R = 13'h0100, K_PCW = 13'h0080;
  localparam logic [12:0] K_PCS = 13'h0040, K_IOD = 13'h0020, K_MRD = 13'h0010;
  localparam logic [12:0] K_MWR = 13'h0008, K_MDR = 13'h0004, K_ILL = 13'h0002;
  localparam logic [12:0] K_HLT = 13'h0001;
  localparam logic [12:0] K_F   = K_MRD | K_PCW;
  localparam logic [12:0] K_D   = K_RA | K_RB | K_AO;

  typedef struct packed {
    logic [15:0] instr;
    logic [2:0]  rd, rm, rn;
    logic        a_sel;
    logic [1:0]  b_sel, imm_sel;
    logic        alu_ctl;
    logic [12:0] strobes;
  } obs_t;

  typedef struct packed {
    logic        rdy;
    logic [15:0] rdata;
    logic [3:0]  nzvc;
    logic [12:0] exp_str;
    logic [2:0]  rd, rm, rn;
  } vec_t;

  // Phases of one instruction as the reference model sees them.
  typedef enum { P_FETCH, P_DECODE, P_ALU, P_WB_ALU, P_ADDR, P_RD, P_WB_MEM,
                 P_WR, P_BR, P_HALT } step_e;

  logic [12:0] strobes;
  obs_t        obs;
  assign strobes = {RA_Data_CE, RB_Data_CE, ALUOut_CE, RF_Write_en, Mem_to_RF_Sel,
                    PC_Write_en, PC_Src, IorD, Mem_Read, Mem_Write, MDR_CE,
                    illegal, halted};
  assign obs = {Instr, Rd_ddd_to_RF, Rm_mmm_to_RF, Rn_nnn_to_RF, ALU_A_Sel,
                ALU_B_Sel, Imm_Sel, ALU_Control, strobes};

  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_ir;
  logic        m_z;
  step_e       plan_q[$];
  vec_t        tv[26];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs for one cycle of an instruction phase.
  function automatic obs_t model_out(input step_e s, input logic [15:0] ir,
                                     input logic rdy, input logic z);
    obs_t o;
    logic [4:0] op;
    op = ir[15:11];
    o.instr = ir;
    o.rd = ir[10:8];
    o.rm = (op == 5'd4) ? ir[10:8] : ir[7:5];
    o.rn = (op == 5'd6) ? ir[10:8] : ir[4:2];
    o.a_sel = 1'b1; o.b_sel = 2'b00; o.imm_sel = 2'b00; o.alu_ctl = 1'b0;
    o.strobes = '0;
    case (s)
      P_FETCH:  begin o.a_sel = 1'b0; o.b_sel = 2'b10; o.strobes = K_MRD | (rdy ? K_PCW : 13'h0); end
      P_DECODE: begin
        o.a_sel = 1'b0; o.b_sel = 2'b01; o.imm_sel = 2'b01;
        o.strobes = K_D | ((op > 5'd9 && op != 5'd31) ? K_ILL : 13'h0);
      end
      P_ALU: begin
        o.b_sel   = (op == 5'd0 || op == 5'd1 || op == 5'd9) ? 2'b00 : 2'b01;
        o.imm_sel = (op == 5'd4) ? 2'b01 : 2'b00;
        o.alu_ctl = (op == 5'd1 || op == 5'd3 || op == 5'd9);
        o.strobes = K_AO;
      end
      P_WB_ALU: o.strobes = K_RFW;
      P_ADDR:   begin o.b_sel = 2'b01; o.strobes = K_AO; end
      P_RD:     o.strobes = K_MRD | K_IOD | (rdy ? K_MDR : 13'h0);
      P_WB_MEM: o.strobes = K_RFW | K_M2R;
      P_WR:     o.strobes = K_MWR | K_IOD;
      P_BR:     o.strobes = K_PCS | ((op == 5'd7 || (op == 5'd8 && z)) ? K_PCW : 13'h0);
      P_HALT:   o.strobes = K_HLT;
      default:  ;
    endcase
    return o;
  endfunction

  // Phases after FETCH for a given opcode.
  task automatic build_plan(input logic [4:0] op);
    plan_q.delete();
    plan_q.push_back(P_DECODE);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4: begin plan_q.push_back(P_ALU); plan_q.push_back(P_WB_ALU); end
      5'd9:       plan_q.push_back(P_ALU);
      5'd5:       begin plan_q.push_back(P_ADDR); plan_q.push_back(P_RD); plan_q.push_back(P_WB_MEM); end
      5'd6:       begin plan_q.push_back(P_ADDR); plan_q.push_back(P_WR); end
      5'd7, 5'd8: plan_q.push_back(P_BR);
      5'd31:      plan_q.push_back(P_HALT);
      default:    ;
    endcase
  endtask

  function automatic logic [15:0] pick_instr();
    int k;
    logic [4:0] op;
    k = $urandom_range(0, 11);
    if (k <= 9) op = 5'(k);
    else        op = 5'(10 + $urandom_range(0, 20));
    return {op, 11'($urandom)};
  endfunction

  // Assert reset at a point after a rising edge; ends released, in the input-drive slot.
  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b1; NZVC = '0; mem_rdata = 16'h0174;
    #1;
    check("rst_strobes", 64'(strobes), 64'h0);
    check("rst_ir", 64'(Instr), 64'h0);
    @(negedge clk);
    check("rst_hold_strobes", 64'(strobes), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ir = '0; m_z = 1'b0;
  endtask

  // One random instruction, fetch to last phase, with random wait states.
  task automatic rand_instr();
    int   waits;
    logic rdy;
    step_e s;
    waits = 0;
    do begin
      mem_rdata = pick_instr(); NZVC = 4'($urandom);
      mem_ready = (waits >= 3) || ($urandom_range(0, 1) == 1);
      rdy = WAIT_EN ? mem_ready : 1'b1;
      @(negedge clk);
      check("rnd_fetch", 64'(obs), 64'(model_out(P_FETCH, m_ir, rdy, m_z)));
      @(posedge clk); #1;
      if (rdy) m_ir = mem_rdata;
      waits++;
    end while (!rdy);
    build_plan(m_ir[15:11]);
    foreach (plan_q[k]) begin
      s = plan_q[k];
      waits = 0;
      do begin
        mem_rdata = 16'($urandom); NZVC = 4'($urandom);
        mem_ready = (waits >= 3) || ($urandom_range(0, 1) == 1);
        rdy = WAIT_EN ? mem_ready : 1'b1;
        @(negedge clk);
        check($sformatf("rnd_%s_op%0d", s.name(), m_ir[15:11]), 64'(obs),
              64'(model_out(s, m_ir, rdy, m_z)));
        @(posedge clk); #1;
        if (s == P_ALU) m_z = NZVC[2];
        waits++;
      end while ((s == P_RD || s == P_WR) && !rdy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_wait;

    // Directed ADD, CMP/BEQ taken, CMP/BEQ not taken, STR, illegal, ADDI8.
    tv[0]  = '{1'b1, 16'h0174, 4'h0, K_F,           3'd0, 3'd0, 3'd0};
    tv[1]  = '{1'b1, 16'h0174, 4'h0, K_D,           3'd1, 3'd3, 3'd5};
    tv[2]  = '{1'b1, 16'h0174, 4'h0, K_AO,          3'd1, 3'd3, 3'd5};
    tv[3]  = '{1'b1, 16'h0174, 4'h0, K_RFW,         3'd1, 3'd3, 3'd5};
    tv[4]  = '{1'b1, 16'h486C, 4'h0, K_F,           3'd1, 3'd3, 3'd5};
    tv[5]  = '{1'b1, 16'h486C, 4'h0, K_D,           3'd0, 3'd3, 3'd3};
    tv[6]  = '{1'b1, 16'h486C, 4'h4, K_AO,          3'd0, 3'd3, 3'd3};
    tv[7]  = '{1'b1, 16'h4005, 4'h0, K_F,           3'd0, 3'd3, 3'd3};
    tv[8]  = '{1'b1, 16'h4005, 4'h0, K_D,           3'd0, 3'd0, 3'd1};
    tv[9]  = '{1'b1, 16'h4005, 4'h0, K_PCW | K_PCS, 3'd0, 3'd0, 3'd1};
    tv[10] = '{1'b1, 16'h486C, 4'h0, K_F,           3'd0, 3'd0, 3'd1};
    tv[11] = '{1'b1, 16'h486C, 4'h0, K_D,           3'd0, 3'd3, 3'd3};
    tv[12] = '{1'b1, 16'h486C, 4'h0, K_AO,          3'd0, 3'd3, 3'd3};
    tv[13] = '{1'b1, 16'h4005, 4'h0, K_F,           3'd0, 3'd3, 3'd3};
    tv[14] = '{1'b1, 16'h4005, 4'h0, K_D,           3'd0, 3'd0, 3'd1};
    tv[15] = '{1'b1, 16'h4005, 4'h0, K_PCS,         3'd0, 3'd0, 3'd1};
    tv[16] = '{1'b1, 16'h3284, 4'h0, K_F,           3'd0, 3'd0, 3'd1};
    tv[17] = '{1'b1, 16'h3284, 4'h0, K_D,           3'd2, 3'd4, 3'd2};
    tv[18] = '{1'b1, 16'h3284, 4'h0, K_AO,          3'd2, 3'd4, 3'd2};
    tv[19] = '{1'b1, 16'h3284, 4'h0, K_MWR | K_IOD, 3'd2, 3'd4, 3'd2};
    tv[20] = '{1'b1, 16'hA800, 4'h0, K_F,           3'd2, 3'd4, 3'd2};
    tv[21] = '{1'b1, 16'hA800, 4'h0, K_D | K_ILL,   3'd0, 3'd0, 3'd0};
    tv[22] = '{1'b1, 16'h2307, 4'h0, K_F,           3'd0, 3'd0, 3'd0};
    tv[23] = '{1'b1, 16'h2307, 4'h0, K_D,           3'd3, 3'd3, 3'd1};
    tv[24] = '{1'b1, 16'h2307, 4'h0, K_AO,          3'd3, 3'd3, 3'd1};
    tv[25] = '{1'b1, 16'h2307, 4'h0, K_RFW,         3'd3, 3'd3, 3'd1};

    do_reset();
    for (int i = 0; i < 26; i++) begin
      mem_ready = tv[i].rdy; mem_rdata = tv[i].rdata; NZVC = tv[i].nzvc;
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'({strobes, Rd_ddd_to_RF, Rm_mmm_to_RF, Rn_nnn_to_RF}),
            64'({tv[i].exp_str, tv[i].rd, tv[i].rm, tv[i].rn}));
      @(posedge clk); #1;
    end

    // LDR with wait states in MEM_RD (none when waits are compiled out).
    n_wait = WAIT_EN ? 2 : 0;
    mem_ready = 1'b1; mem_rdata = 16'h2A60;
    @(negedge clk); check("ldr_fetch", 64'(strobes), 64'(K_F));
    @(posedge clk); #1;
    @(negedge clk); check("ldr_decode", 64'(strobes), 64'(K_D));
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk); check("ldr_addr", 64'(strobes), 64'(K_AO));
    @(posedge clk); #1;
    for (int i = 0; i <= n_wait; i++) begin
      mem_ready = WAIT_EN ? (i == n_wait) : 1'b0;
      @(negedge clk);
      check($sformatf("ldr_memrd%0d", i), 64'(strobes),
            64'(K_MRD | K_IOD | ((i == n_wait) ? K_MDR : 13'h0)));
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk); check("ldr_wbmem", 64'(strobes), 64'(K_RFW | K_M2R));
    @(posedge clk); #1;

    // Asynchronous reset in the middle of EXEC of an ADD.
    mem_ready = 1'b1; mem_rdata = 16'h0174;
    @(negedge clk); check("arst_fetch", 64'(strobes), 64'(K_F));
    @(posedge clk); #1;
    @(negedge clk); check("arst_decode", 64'(strobes), 64'(K_D));
    @(posedge clk); #1;
    @(negedge clk); check("arst_exec", 64'(strobes), 64'(K_AO));
    #1 rst = 1'b1;
    #1;
    check("arst_strobes_drop", 64'(strobes), 64'h0);
    check("arst_ir_clear", 64'(Instr), 64'h0);
    @(posedge clk); @(posedge clk); #1;
    mem_rdata = 16'hA800; rst = 1'b0;
    @(negedge clk);
    check("arst_first_fetch", 64'(strobes), 64'(K_F));
    @(posedge clk); #1;
    @(negedge clk); check("arst_illegal_decode", 64'(strobes), 64'(K_D | K_ILL));
    @(posedge clk); #1;

    // Random instruction stream against the reference model.
    do_reset();
    for (int i = 0; i < 250; i++) rand_instr();

    // HALT: stays halted with no strobes whatever the inputs do.
    mem_ready = 1'b1; mem_rdata = 16'hF800;
    @(negedge clk); check("halt_fetch", 64'(strobes), 64'(K_F));
    @(posedge clk); #1;
    @(negedge clk); check("halt_decode", 64'(strobes), 64'(K_D));
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom); NZVC = 4'($urandom); mem_rdata = 16'($urandom);
      @(negedge clk);
      check($sformatf("halt_hold%0d", i), 64'(strobes), 64'(K_HLT));
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc16_control_unit.md
# mc16_control_unit

Multi-cycle control FSM for the 16-bit RISC computer. It drives the RF+ALU datapath, consuming the datapath's `NZVC` flags and producing its selects and clock enables. It owns the instruction register (IR), the stored flag register and the memory read/write strobes. It sequences each instruction through fetch, decode, execute, memory and write-back states.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_rdata` in 16: memory read data, loaded into the IR during fetch.
- `mem_ready` in 1: memory access completes this cycle.
- `NZVC` in 4: combinational ALU flags from the datapath.
- `Instr` out 16: IR contents, fed to the datapath immediate extender.
- `Rd_ddd_to_RF`, `Rm_mmm_to_RF`, `Rn_nnn_to_RF` out 3 each: RF addresses.
- `ALU_A_Sel` out 1: 0 selects PC, 1 selects RF.
- `ALU_B_Sel` out 2: 00 selects RF, 01 selects immediate, 10 selects constant 1, 11 selects constant 0.
- `Imm_Sel` out 2: 00 selects simm5, 01 selects simm8, 10 selects zimm8, 11 selects 0.
- `ALU_Control` out 1: 0 = add, 1 = subtract.
- `RA_Data_CE`, `RB_Data_CE`, `ALUOut_CE`, `RF_Write_en`, `Mem_to_RF_Sel` out 1 each: datapath enables and write-back select.
- `PC_Write_en` out 1: PC load enable.
- `PC_Src` out 1: 0 loads PC from ALU_S, 1 loads PC from ALU_Out.
- `IorD` out 1: memory address source; 0 = PC, 1 = ALU_Out.
- `Mem_Read`, `Mem_Write`, `MDR_CE` out 1 each: memory strobes and memory data register enable.
- `halted`, `illegal` out 1 each: status outputs.

## Operation
- Instruction fields:
  - opcode = IR[15:11]
  - d = IR[10:8], m = IR[7:5], n = IR[4:2]
- Opcodes:
  - 00000 ADD d=m+n
  - 00001 SUB d=m−n
  - 00010 ADDI d=m+simm5
  - 00011 SUBI d=m−simm5
  - 00100 ADDI8 d=d+simm8
  - 00101 LDR d=[m+simm5]
  - 00110 STR [m+simm5]=d
  - 00111 B
  - 01000 BEQ (taken if stored Z=1)
  - 01001 CMP m−n (updates flags only)
  - 11111 HALT
- Any other opcode: `illegal` pulses for 1 cycle in DECODE, then the FSM returns to FETCH (executes as a NOP).
- Register address outputs:
  - `Rd` = d.
  - `Rm` = d for ADDI8, otherwise m.
  - `Rn` = d for STR, otherwise n.
- FSM states:
  - FETCH: `Mem_Read`=1, `IorD`=0. ALU computes PC+1 (A_Sel=0, B_Sel=10, add). Held until `mem_ready`. On ready, the IR loads `mem_rdata`, `PC_Write_en`=1, `PC_Src`=0, next state is DECODE.
  - DECODE: `RA_Data_CE`=`RB_Data_CE`=1. `ALUOut_CE`=1 with A=PC, B=simm8 (branch target). Next state by opcode: B/BEQ → BRANCH, HALT → HALTED, illegal → FETCH, LDR/STR → MEM_ADDR, others → EXEC.
  - EXEC: A=RF. B=RF (ADD/SUB/CMP) or immediate. `ALU_Control`=1 for SUB/SUBI/CMP. `ALUOut_CE`=1. Flag register ← `NZVC`. CMP → FETCH; others → WB_ALU.
  - WB_ALU: `RF_Write_en`=1, `Mem_to_RF_Sel`=0. Next state FETCH.
  - MEM_ADDR: ALUOut ← RA+simm5; flags unchanged. LDR → MEM_RD, STR → MEM_WR.
  - MEM_RD: `Mem_Read`=1, `IorD`=1, `MDR_CE`=`mem_ready`. Held until `mem_ready`, then WB_MEM.
  - WB_MEM: `RF_Write_en`=1, `Mem_to_RF_Sel`=1. Next state FETCH.
  - MEM_WR: `Mem_Write`=1, `IorD`=1. Held until `mem_ready`, then FETCH.
  - BRANCH: `PC_Write_en`=1 if B, or if BEQ with Z=1; `PC_Src`=1. Next state FETCH.
  - HALTED: `halted`=1; all strobes 0. Exited only by `rst`.
- Every enable, strobe and write signal not listed for a state is 0 in that state.
- Select lines are don't-care where unused, but are driven to fixed values (A_Sel=1, B_Sel=00, Imm_Sel=00).

## Timing
- Outputs decode from the registered state and IR (Moore), except the FETCH/MEM_RD completion enables, which are gated by `mem_ready`.
- Latency with zero wait states:
  - ADD/SUB/ADDI/SUBI/ADDI8: 4 cycles.
  - CMP: 3 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B/BEQ: 3 cycles.
- Each idle `mem_ready` cycle adds 1 cycle.
- Reset values: state=FETCH, IR=0, flags=0, `halted`=0, `illegal`=0.
- Asynchronous reset mid-instruction aborts the instruction immediately:
  - All `*_CE`, `RF_Write_en`, `PC_Write_en`, `Mem_Read`, `Mem_Write` drop at reset assertion.
  - The first FETCH begins on the first rising edge after `rst` deasserts.
- A `mem_ready` arriving in a state that is not waiting for memory is ignored.

## Configuration
- `MC16_MEM_WAIT_EN`:
  - Defined: FETCH/MEM_RD/MEM_WR wait for `mem_ready` as described.
  - Undefined: `mem_ready` is ignored and treated as 1; every memory access completes in one cycle.

## Test plan
- Reset: assert `rst` mid-EXEC → all strobes 0 asynchronously; after release, the first cycle is FETCH with `Mem_Read`=1, `IorD`=0.
- ADD: fetch 16'h0174 (ADD d=1,m=3,n=5), `mem_ready`=1 every cycle → `RF_Write_en`=1 with `Rd`=1 exactly 3 cycles after the IR load, `Mem_to_RF_Sel`=0.
- LDR with 2 wait states: MEM_RD is held 3 cycles, `MDR_CE` asserts only on the ready cycle, then WB_MEM has `Mem_to_RF_Sel`=1.
- CMP then BEQ: CMP R3,R3 with `NZVC`=0100 in EXEC, then BEQ → BRANCH asserts `PC_Write_en`=1, `PC_Src`=1. Repeat with `NZVC`=0000 → `PC_Write_en`=0.
- STR: opcode 00110 → `Rn`=d field, `Mem_Write`=1, `IorD`=1 until `mem_ready`, no RF write.
- Illegal opcode 10101 → `illegal`=1 for 1 cycle, then FETCH. HALT → `halted`=1, no strobes for 20 cycles.
